// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 measurement transmitter: FSM encoding,
// ASCII constants and line lengths.
package dht11_pkg;

   typedef enum logic [3:0] {
      OCIOSO    = 4'd0,
      PEDE      = 4'd1,
      ESPERA    = 4'd2,
      ENVIA     = 4'd3,
      ESPERA_TX = 4'd4,
      FIM       = 4'd5
   } estado_t;

   localparam logic [7:0] ASCII_T      = 8'h54;
   localparam logic [7:0] ASCII_U      = 8'h55;
   localparam logic [7:0] ASCII_PONTO  = 8'h2E;
   localparam logic [7:0] ASCII_ESPACO = 8'h20;
   localparam logic [7:0] ASCII_E      = 8'h45;
   localparam logic [7:0] ASCII_R      = 8'h52;
   localparam logic [7:0] ASCII_O      = 8'h4F;
   localparam logic [7:0] ASCII_CR     = 8'h0D;
   localparam logic [7:0] ASCII_LF     = 8'h0A;
   localparam logic [7:0] ASCII_ZERO   = 8'h30;

   localparam int TAM_LINHA_DADOS = 13;
   localparam int TAM_LINHA_ERRO  = 6;

endpackage

// File: rtl/conversor_ascii_dht11.sv
// Turns one DHT11 word (integer byte + decimal byte) into three ASCII digits,
// clamping the integer part to 99 and the decimal part to 9.
module conversor_ascii_dht11 (
   input  logic [7:0] inteiro,
   input  logic [7:0] decimal,
   output logic [7:0] dezena,
   output logic [7:0] unidade,
   output logic [7:0] decimo
);
   import dht11_pkg::*;

   logic [7:0] int_lim;
   logic [7:0] dec_lim;

   // The leading zero is kept so the line always has a fixed width.
   always_comb begin
      int_lim = (inteiro > 8'd99) ? 8'd99 : inteiro;
      dec_lim = (decimal > 8'd9) ? 8'd9 : decimal;
      dezena  = ASCII_ZERO + (int_lim / 8'd10);
      unidade = ASCII_ZERO + (int_lim % 8'd10);
      decimo  = ASCII_ZERO + dec_lim;
   end

endmodule

// File: rtl/transmissor_medidas_dht11.sv
// Schedules DHT11 measurements and streams the result (or an error line)
// to the UART one byte at a time through a start/done handshake.
module transmissor_medidas_dht11 #(
   parameter int PERIODO        = 100_000_000,
   parameter int TIMEOUT_MEDIDA = 50_000_000,
   parameter int LARGURA_CONT   = 27
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        habilita,
   input  logic        medir,
   input  logic        pronto_medida,
   input  logic        erro_medida,
   input  logic [15:0] temperatura_in,
   input  logic [15:0] umidade_in,
   output logic        medir_dht11,
   output logic [7:0]  tx_dado,
   output logic        tx_partida,
   input  logic        tx_pronto,
   output logic        pronto,
   output logic [3:0]  db_estado
);
   import dht11_pkg::*;

   localparam logic [LARGURA_CONT-1:0] FIM_PERIODO = LARGURA_CONT'(PERIODO - 1);
   localparam logic [LARGURA_CONT-1:0] FIM_TIMEOUT = LARGURA_CONT'(TIMEOUT_MEDIDA - 1);
   localparam logic [3:0] ULTIMO_DADOS = 4'(TAM_LINHA_DADOS - 1);
   localparam logic [3:0] ULTIMO_ERRO  = 4'(TAM_LINHA_ERRO - 1);

   estado_t estado, estado_prox;
   logic [LARGURA_CONT-1:0] cont_periodo, cont_timeout;
   logic        pendente, linha_erro, tick, falha, ultimo;
   logic [15:0] temp_reg, umid_reg;
   logic [3:0]  indice;
   logic [7:0]  t_dez, t_uni, t_dec, u_dez, u_uni, u_dec, caractere;

   assign tick      = habilita && (cont_periodo == FIM_PERIODO);
   assign falha     = erro_medida || (cont_timeout == FIM_TIMEOUT);
   assign ultimo    = (indice == (linha_erro ? ULTIMO_ERRO : ULTIMO_DADOS));
   assign db_estado = estado;

   // One-deep request flag: acceptance in OCIOSO wins over a simultaneous new request.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cont_periodo <= '0;
         pendente     <= 1'b0;
      end else begin
         if (!habilita || tick)
            cont_periodo <= '0;
         else
            cont_periodo <= cont_periodo + 1'b1;
         if (estado == OCIOSO && pendente)
            pendente <= 1'b0;
         else if (tick || medir)
            pendente <= 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cont_timeout <= '0;
         indice       <= '0;
         linha_erro   <= 1'b0;
         temp_reg     <= '0;
         umid_reg     <= '0;
      end else begin
         case (estado)
            PEDE: cont_timeout <= '0;
            ESPERA: begin
               cont_timeout <= cont_timeout + 1'b1;
               if (falha) begin
                  linha_erro <= 1'b1;
               end else if (pronto_medida) begin
                  linha_erro <= 1'b0;
                  temp_reg   <= temperatura_in;
                  umid_reg   <= umidade_in;
               end
            end
            ESPERA_TX: if (tx_pronto && !ultimo) indice <= indice + 1'b1;
            FIM: indice <= '0;
            default: ;
         endcase
      end
   end

   conversor_ascii_dht11 u_conv_temp (
      .inteiro (temp_reg[15:8]),
      .decimal (temp_reg[7:0]),
      .dezena  (t_dez),
      .unidade (t_uni),
      .decimo  (t_dec)
   );

   conversor_ascii_dht11 u_conv_umid (
      .inteiro (umid_reg[15:8]),
      .decimal (umid_reg[7:0]),
      .dezena  (u_dez),
      .unidade (u_uni),
      .decimo  (u_dec)
   );

   always_comb begin
      caractere = ASCII_LF;
      if (linha_erro) begin
         case (indice)
            4'd0: caractere = ASCII_E;
            4'd1: caractere = ASCII_R;
            4'd2: caractere = ASCII_R;
            4'd3: caractere = ASCII_O;
            4'd4: caractere = ASCII_CR;
            default: ;
         endcase
      end else begin
         case (indice)
            4'd0:  caractere = ASCII_T;
            4'd1:  caractere = t_dez;
            4'd2:  caractere = t_uni;
            4'd3:  caractere = ASCII_PONTO;
            4'd4:  caractere = t_dec;
            4'd5:  caractere = ASCII_ESPACO;
            4'd6:  caractere = ASCII_U;
            4'd7:  caractere = u_dez;
            4'd8:  caractere = u_uni;
            4'd9:  caractere = ASCII_PONTO;
            4'd10: caractere = u_dec;
            4'd11: caractere = ASCII_CR;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         estado <= OCIOSO;
      else
         estado <= estado_prox;
   end

   // tx_dado is driven only while a byte is in flight, so it reads 0 when idle.
   always_comb begin
      estado_prox = estado;
      medir_dht11 = 1'b0;
      tx_partida  = 1'b0;
      pronto      = 1'b0;
      tx_dado     = 8'h00;
      case (estado)
         OCIOSO: if (pendente) estado_prox = PEDE;
         PEDE: begin
            medir_dht11 = 1'b1;
            estado_prox = ESPERA;
         end
         ESPERA: if (falha || pronto_medida) estado_prox = ENVIA;
         ENVIA: begin
            tx_dado     = caractere;
            tx_partida  = 1'b1;
            estado_prox = ESPERA_TX;
         end
         ESPERA_TX: begin
            tx_dado = caractere;
            if (tx_pronto) estado_prox = ultimo ? FIM : ENVIA;
         end
         FIM: begin
            pronto      = 1'b1;
            estado_prox = OCIOSO;
         end
         default: estado_prox = OCIOSO;
      endcase
   end

endmodule

// File: tb/tb_transmissor_medidas_dht11.sv
// Self-checking bench: randomized measurements and UART timing, with expected
// lines formatted from the readings by a string-level reference model.
module tb_transmissor_medidas_dht11;

   localparam int PER = 1000;
   localparam int TMO = 20;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        habilita = 1'b0;
   logic        medir = 1'b0;
   logic        pronto_medida = 1'b0;
   logic        erro_medida = 1'b0;
   logic        tx_pronto = 1'b0;
   logic [15:0] temperatura_in = 16'h0;
   logic [15:0] umidade_in = 16'h0;
   logic        medir_dht11, tx_partida, pronto;
   logic [7:0]  tx_dado;
   logic [3:0]  db_estado;

   int nchecks = 0, nfails = 0;
   int ciclo = 0, ntx = 0, nmedir = 0, npronto = 0;
   int t_medir = 0, t_pronto = 0, t_tx0 = 0, geracao = 0, uart_atraso = 10;
   bit auto_dht = 1'b0;
   logic [7:0] linha_q[$];
   logic [7:0] exp_bytes[$];
   int exp_len[$];
   int int_q[$];

   transmissor_medidas_dht11 #(
      .PERIODO        (PER),
      .TIMEOUT_MEDIDA (TMO),
      .LARGURA_CONT   (27)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .habilita       (habilita),
      .medir          (medir),
      .pronto_medida  (pronto_medida),
      .erro_medida    (erro_medida),
      .temperatura_in (temperatura_in),
      .umidade_in     (umidade_in),
      .medir_dht11    (medir_dht11),
      .tx_dado        (tx_dado),
      .tx_partida     (tx_partida),
      .tx_pronto      (tx_pronto),
      .pronto         (pronto),
      .db_estado      (db_estado)
   );

   always #5 clock = ~clock;
   always @(posedge clock) ciclo <= ciclo + 1;

   task checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      nchecks++;
      if (obs !== esp) begin
         nfails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, esp);
      end
   endtask

   // Reference model: the line a reading should produce, as text.
   function automatic void espera_linha(input logic [15:0] t, input logic [15:0] u, input bit e);
      string s;
      int ti, td, ui, ud;
      if (e) begin
         s = $sformatf("ERRO%c%c", 8'd13, 8'd10);
      end else begin
         ti = (int'(t[15:8]) > 99) ? 99 : int'(t[15:8]);
         td = (int'(t[7:0]) > 9) ? 9 : int'(t[7:0]);
         ui = (int'(u[15:8]) > 99) ? 99 : int'(u[15:8]);
         ud = (int'(u[7:0]) > 9) ? 9 : int'(u[7:0]);
         s = $sformatf("T%02d.%0d U%02d.%0d%c%c", ti, td, ui, ud, 8'd13, 8'd10);
      end
      for (int i = 0; i < s.len(); i++) exp_bytes.push_back(s[i]);
      exp_len.push_back(s.len());
   endfunction

   task automatic confere_linha();
      int n;
      logic [7:0] e;
      if (exp_len.size() == 0) begin
         checkOutput("linha_inesperada", 32'(exp_len.size()), 32'd1);
         return;
      end
      n = exp_len.pop_front();
      checkOutput("tam_linha", 32'(linha_q.size()), 32'(n));
      for (int i = 0; i < n; i++) begin
         e = exp_bytes.pop_front();
         if (i < linha_q.size()) checkOutput($sformatf("byte%0d", i), 32'(linha_q[i]), 32'(e));
      end
   endtask

   // Monitor: gathers transmitted bytes and event times away from the active edge.
   always @(negedge clock) begin
      if (!reset) begin
         if (tx_partida) begin
            if (linha_q.size() == 0) t_tx0 = ciclo;
            linha_q.push_back(tx_dado);
            ntx++;
         end
         if (medir_dht11) begin
            checkOutput("exclusao_partida_medir", 32'(tx_partida), 32'd0);
            if (nmedir > 0) int_q.push_back(ciclo - t_medir);
            t_medir = ciclo;
            nmedir++;
         end
         if (pronto) begin
            npronto++;
            t_pronto = ciclo;
            confere_linha();
            linha_q.delete();
         end
      end
   end

   // UART model: acknowledges each byte after uart_atraso cycles.
   initial forever begin
      @(negedge clock);
      if (tx_partida && !reset) begin
         logic [7:0] b;
         int g;
         b = tx_dado;
         g = geracao;
         repeat (uart_atraso) @(posedge clock);
         @(negedge clock);
         if (g == geracao) checkOutput("tx_dado_estavel", 32'(tx_dado), 32'(b));
         tx_pronto = 1'b1;
         @(posedge clock);
         #1 tx_pronto = 1'b0;
      end
   end

   // Automatic sensor model used during periodic and merge phases.
   initial forever begin
      @(negedge clock);
      if (medir_dht11 && auto_dht && !reset) begin
         logic [15:0] t, u;
         bit e;
         repeat ($urandom_range(2, 8)) @(posedge clock);
         #1;
         t = 16'($urandom);
         u = 16'($urandom);
         e = ($urandom_range(0, 3) == 0);
         temperatura_in = t;
         umidade_in = u;
         if (e) erro_medida = 1'b1;
         else pronto_medida = 1'b1;
         espera_linha(t, u, e);
         @(posedge clock);
         #1;
         pronto_medida = 1'b0;
         erro_medida = 1'b0;
         temperatura_in = 16'($urandom);
         umidade_in = 16'($urandom);
      end
   end

   function automatic int le(input int w);
      case (w)
         0: return ntx;
         1: return nmedir;
         default: return npronto;
      endcase
   endfunction

   task automatic espera_n(input int w, input int alvo, input int budget, input string tag);
      int i = 0;
      while (le(w) < alvo && i < budget) begin
         @(negedge clock);
         #1;
         i++;
      end
      if (le(w) < alvo) checkOutput({tag, "_espera"}, 32'(le(w)), 32'(alvo));
   endtask

   task pulso_medir();
      @(posedge clock);
      #1 medir = 1'b1;
      @(posedge clock);
      #1 medir = 1'b0;
   endtask

   // modo: 0 = valid reading, 1 = sensor error, 2 = both pulses at once.
   task responde(input logic [15:0] t, input logic [15:0] u, input int modo);
      repeat (3) @(posedge clock);
      #1;
      temperatura_in = t;
      umidade_in = u;
      pronto_medida = (modo != 1);
      erro_medida = (modo != 0);
      espera_linha(t, u, modo != 0);
      @(posedge clock);
      #1;
      pronto_medida = 1'b0;
      erro_medida = 1'b0;
      temperatura_in = 16'($urandom);
      umidade_in = 16'($urandom);
   endtask

   task automatic applyStimulus(input logic [15:0] t, input logic [15:0] u, input int modo);
      int m0, p0;
      m0 = nmedir;
      p0 = npronto;
      pulso_medir();
      espera_n(1, m0 + 1, 50, "pedido");
      responde(t, u, modo);
      repeat (20) @(negedge clock);
      pronto_medida = 1'b1;
      erro_medida = 1'b1;
      temperatura_in = ~t;
      @(negedge clock);
      pronto_medida = 1'b0;
      erro_medida = 1'b0;
      espera_n(2, p0 + 1, 600, "fim_linha");
      repeat (5) @(negedge clock);
   endtask

   initial begin
      int m0, p0, t0;
      repeat (3) @(posedge clock);
      #1;
      checkOutput("reset_medir_dht11", 32'(medir_dht11), 32'd0);
      checkOutput("reset_tx_partida", 32'(tx_partida), 32'd0);
      checkOutput("reset_tx_dado", 32'(tx_dado), 32'd0);
      checkOutput("reset_pronto", 32'(pronto), 32'd0);
      checkOutput("reset_db_estado", 32'(db_estado), 32'd0);
      @(negedge clock) reset = 1'b0;
      repeat (5) @(negedge clock);

      uart_atraso = 10;
      applyStimulus(16'h1903, 16'h3C00, 0);
      applyStimulus(16'h1903, 16'h3C00, 1);
      applyStimulus(16'h7F0C, 16'h0500, 0);
      applyStimulus(16'h0000, 16'hFFFF, 2);
      for (int i = 0; i < 10; i++) begin
         uart_atraso = $urandom_range(1, 12);
         applyStimulus(16'($urandom), 16'($urandom), $urandom_range(0, 2));
      end
      uart_atraso = 10;

      // No reply: the error line must start TMO cycles after ESPERA is entered.
      espera_linha(16'h0, 16'h0, 1'b1);
      m0 = nmedir;
      t0 = ntx;
      p0 = npronto;
      pulso_medir();
      espera_n(1, m0 + 1, 50, "timeout_medir");
      espera_n(0, t0 + 1, 100, "timeout_tx");
      checkOutput("latencia_timeout", 32'(t_tx0 - t_medir), 32'(TMO + 1));
      espera_n(2, p0 + 1, 500, "timeout_fim");
      repeat (10) @(negedge clock);

      // Periodic requests, then a tick landing while a line is in flight.
      auto_dht = 1'b1;
      int_q.delete();
      m0 = nmedir;
      habilita = 1'b1;
      espera_n(1, m0 + 4, 5000, "periodo");
      for (int i = 1; i < 4; i++)
         if (i < int_q.size()) checkOutput($sformatf("intervalo%0d", i), 32'(int_q[i]), 32'(PER));
      repeat (948) @(negedge clock);
      m0 = nmedir;
      pulso_medir();
      espera_n(1, m0 + 2, 1500, "tick_pendente");
      checkOutput("tick_apos_fim", 32'(t_medir - t_pronto), 32'd2);
      habilita = 1'b0;
      p0 = npronto;
      espera_n(2, p0 + 1, 600, "tick_fim");
      repeat (100) @(negedge clock);

      // Three requests during one line merge into a single extra measurement.
      m0 = nmedir;
      p0 = npronto;
      t0 = ntx;
      pulso_medir();
      espera_n(0, t0 + 1, 100, "merge_tx");
      repeat (3) begin
         repeat (10) @(negedge clock);
         pulso_medir();
      end
      espera_n(2, p0 + 2, 2000, "merge_pronto");
      repeat (300) @(negedge clock);
      checkOutput("merge_medidas", 32'(nmedir - m0), 32'd2);
      checkOutput("merge_linhas", 32'(npronto - p0), 32'd2);
      auto_dht = 1'b0;

      // Reset in the middle of the 5th byte aborts the line.
      m0 = nmedir;
      t0 = ntx;
      pulso_medir();
      espera_n(1, m0 + 1, 50, "reset_pedido");
      responde(16'h1903, 16'h3C00, 0);
      espera_n(0, t0 + 5, 300, "quinto_byte");
      reset = 1'b1;
      geracao++;
      #1;
      checkOutput("abort_tx_partida", 32'(tx_partida), 32'd0);
      checkOutput("abort_tx_dado", 32'(tx_dado), 32'd0);
      checkOutput("abort_medir_dht11", 32'(medir_dht11), 32'd0);
      checkOutput("abort_pronto", 32'(pronto), 32'd0);
      checkOutput("abort_db_estado", 32'(db_estado), 32'd0);
      linha_q.delete();
      exp_bytes.delete();
      exp_len.delete();
      t0 = ntx;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      repeat (50) @(negedge clock);
      checkOutput("sem_partida_apos_reset", 32'(ntx - t0), 32'd0);
      applyStimulus(16'h1903, 16'h3C00, 0);

      $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfails);
      $finish;
   end

endmodule

// File: doc/transmissor_medidas_dht11.md
Name: transmissor_medidas_dht11

Overview:
Stage directly downstream of the DHT11 interface. It schedules measurements by pulsing medir_dht11, periodically or on a manual request, and waits for pronto_medida or erro. It latches the 16-bit temperature and humidity words, formats them as an ASCII line and streams that line byte-by-byte to the UART transmitter through a start/done handshake. On a sensor error or a response timeout it sends a fixed error line instead.

Parameters:
PERIODO, 100_000_000, clock cycles between automatic measurements (2 s at 50 MHz); must be >= 2
TIMEOUT_MEDIDA, 50_000_000, max cycles to wait for pronto_medida/erro after a request
LARGURA_CONT, 27, width of the period and timeout counters; must hold max(PERIODO, TIMEOUT_MEDIDA)

Ports:
clock  in  1  system clock; single clock domain
reset  in  1  asynchronous, active-high reset
habilita  in  1  enables automatic periodic measurement
medir  in  1  manual request, one-cycle pulse
pronto_medida  in  1  one-cycle pulse from the DHT11 interface: words valid
erro_medida  in  1  one-cycle pulse from the DHT11 interface: measurement failed
temperatura_in  in  16  [15:8] integer part, [7:0] decimal part
umidade_in  in  16  same format as temperatura_in
medir_dht11  out  1  one-cycle request pulse to the DHT11 interface
tx_dado  out  8  ASCII byte to the UART
tx_partida  out  1  one-cycle start pulse to the UART
tx_pronto  in  1  one-cycle pulse from the UART: byte sent
pronto  out  1  one-cycle pulse after the last byte of a line is sent
db_estado  out  4  current FSM state encoding

Behaviour:
- Reset: all outputs 0, FSM in OCIOSO, counters 0, pending flag 0, latched words 0.
- Request logic:
  - Period counter runs only while habilita=1. At PERIODO-1 it wraps to 0 and sets the pending flag.
  - When habilita=0 the counter is held at 0.
  - A medir pulse also sets the pending flag.
  - The pending flag is one-deep. Requests arriving while it is already set are merged.
  - The flag clears in the cycle OCIOSO accepts it.
  - A request arriving mid-line stays pending and is served after FIM.
- FSM states and transitions:
  - OCIOSO: if the pending flag is set, go to PEDE.
  - PEDE: medir_dht11=1 for exactly one cycle; timeout counter cleared; go to ESPERA.
  - ESPERA: timeout counter increments each cycle.
    - pronto_medida: latch both words, select the data line, go to ENVIA.
    - erro_medida, or counter reaches TIMEOUT_MEDIDA-1: select the error line, go to ENVIA.
    - pronto_medida and erro_medida in the same cycle: erro wins.
  - ENVIA: drive tx_dado = character[indice]; tx_partida=1 for one cycle; go to ESPERA_TX.
  - ESPERA_TX: hold tx_dado stable.
    - On tx_pronto: if indice is the last index, go to FIM; otherwise increment indice and go to ENVIA.
  - FIM: pronto=1 for one cycle; indice cleared; go to OCIOSO.
- Line formats:
  - Data line, 13 bytes: 'T', Td1, Td0, '.', Tdec, ' ', 'U', Ud1, Ud0, '.', Udec, 0x0D, 0x0A.
  - Error line, 6 bytes: "ERRO", 0x0D, 0x0A.
- Digit conversion:
  - Integer byte is clamped to 99 and split into tens and units, with a leading zero kept.
  - Decimal byte is clamped to 9.
  - ASCII digit = 0x30 + value.
- Latched words are stable for the whole line; input changes during sending are ignored.
- pronto_medida or erro_medida outside ESPERA is ignored.
- tx_pronto outside ESPERA_TX is ignored.
- Reset mid-line aborts immediately; no partial-line completion.
- tx_partida and medir_dht11 are never asserted in the same cycle.

Decomposition:
- Package dht11_pkg: state encoding (4-bit localparams), ASCII constants ('T','U','.',' ','E','R','O', CR, LF, zero = 0x30), line lengths (13, 6).
- Sub-module conversor_ascii_dht11: combinational. Takes an 8-bit integer byte and an 8-bit decimal byte; outputs three ASCII bytes with clamping.
- Instantiate the sub-module twice, for temperature and humidity.

Test Plan:
- Manual medir; reply pronto_medida with temperatura_in=0x1903 and umidade_in=0x3C00; UART model acknowledges each byte after 10 cycles -> bytes "T25.3 U60.0" followed by CR LF; exactly 13 tx_partida pulses; then one pronto pulse.
- erro_medida after the request -> bytes 0x45 0x52 0x52 0x4F 0x0D 0x0A; then pronto.
- No reply with TIMEOUT_MEDIDA=20 -> error line starts exactly 20 cycles after the ESPERA entry.
- Clamping: temperatura_in=0x7F0C -> "T99.9".
- Clamping: umidade_in=0x0500 -> "U05.0".
- habilita=1 with PERIODO=1000 -> medir_dht11 pulses every 1000 cycles; a tick during sending is delivered after FIM; three medir pulses during one line yield only one extra measurement.
- Reset asserted during the 5th byte -> all outputs 0 immediately; no further tx_partida; next medir restarts the line from 'T'.
